// File: rtl/ps2_rx_fifo_pkg.sv
// ps2_rx_fifo_pkg
//   Shared definitions for the PS/2 receive path: frame FSM state encoding,
//   frame length, common scan codes for the downstream decoder, and the
//   odd-parity helper.
package ps2_rx_fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    // start + 8 data + parity + stop
    localparam int PS2_FRAME_BITS = 11;

    // Scan-code prefixes consumed by the keyboard decoder
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXTEND = 8'hE0;

    // PS/2 uses odd parity: data bits plus parity bit hold an odd number of ones
    function automatic logic parity_ok(input logic [7:0] b, input logic p);
        return ^{b, p};
    endfunction

endpackage

// File: rtl/ps2_rx_fifo_if.sv
// ps2_rx_fifo_if
//   Consumer-side bus of the PS/2 receiver.
//   slave  (receiver): drives data/ready/fill and the sticky flags,
//                      takes nextdata_n (active-low pop) and clr_err.
//   master (consumer): the reverse.
//   FIFO_AW must match the receiver's FIFO_AW (sets the fill width).
interface ps2_rx_fifo_if #(
    parameter int FIFO_AW = 3
) ();
    logic               nextdata_n;
    logic               clr_err;
    logic [7:0]         data;
    logic               ready;
    logic               overflow;
    logic               parity_err;
    logic               frame_err;
    logic [FIFO_AW:0]   fill;

    modport slave (
        input  nextdata_n, clr_err,
        output data, ready, overflow, parity_err, frame_err, fill
    );

    modport master (
        output nextdata_n, clr_err,
        input  data, ready, overflow, parity_err, frame_err, fill
    );
endinterface

// File: rtl/ps2_rx_fifo_frame_rx.sv
// ps2_frame_rx
//   Pin-side half of the receiver: synchronises ps2_clk/ps2_data, debounces
//   ps2_clk, detects its falling edge and assembles 11-bit frames.
//   Ports:
//     clk, clrn          system clock, async active-low reset
//     ps2_clk, ps2_data  raw PS/2 pins
//     rx_byte            last assembled byte (stable while rx_valid is high)
//     rx_valid           one-cycle pulse: good frame received
//     parity_err_p       one-cycle pulse: frame failed odd parity
//     frame_err_p        one-cycle pulse: bad start/stop bit or timeout
module ps2_frame_rx
    import ps2_rx_fifo_pkg::*;
#(
    parameter int SYNC_STAGES    = 3,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       parity_err_p,
    output logic       frame_err_p
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
    logic                   clk_s, dat_s;
    logic [CW-1:0]          flt_cnt;
    logic                   clk_flt, clk_flt_d;
    logic                   strobe;

    ps2_state_e             state;
    logic [2:0]             bit_cnt;
    logic [7:0]             shreg;
    logic                   par_bit;
    logic [TW-1:0]          tmr;

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign dat_s  = dat_sync[SYNC_STAGES-1];
    assign strobe = clk_flt_d & ~clk_flt;
    assign rx_byte = shreg;

    // Synchronisers reset to the idle-high line level so that leaving reset
    // never looks like a clock fall or a start bit.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync <= '1;
            dat_sync <= '1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
        end
    end

    // Filtered clock flips only after FILTER_LEN consecutive samples that
    // disagree with it; any agreeing sample restarts the count.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            flt_cnt   <= '0;
            clk_flt   <= 1'b1;
            clk_flt_d <= 1'b1;
        end else begin
            clk_flt_d <= clk_flt;
            if (clk_s != clk_flt) begin
                if (flt_cnt == CW'(FILTER_LEN - 1)) begin
                    clk_flt <= clk_s;
                    flt_cnt <= '0;
                end else begin
                    flt_cnt <= flt_cnt + 1'b1;
                end
            end else begin
                flt_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            shreg        <= '0;
            par_bit      <= 1'b0;
            tmr          <= '0;
            rx_valid     <= 1'b0;
            parity_err_p <= 1'b0;
            frame_err_p  <= 1'b0;
        end else begin
            rx_valid     <= 1'b0;
            parity_err_p <= 1'b0;
            frame_err_p  <= 1'b0;

            if (strobe || state == ST_IDLE) tmr <= '0;
            else                            tmr <= tmr + 1'b1;

            if (strobe) begin
                case (state)
                    ST_IDLE: begin
                        if (!dat_s) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end else begin
                            frame_err_p <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        shreg   <= {dat_s, shreg[7:1]};   // LSB first
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        par_bit <= dat_s;
                        state   <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (!dat_s)                       frame_err_p  <= 1'b1;
                        else if (parity_ok(shreg, par_bit)) rx_valid   <= 1'b1;
                        else                              parity_err_p <= 1'b1;
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (state != ST_IDLE && tmr == TW'(TIMEOUT_CYCLES - 1)) begin
                // Device stopped clocking mid-frame: drop the partial frame.
                state       <= ST_IDLE;
                frame_err_p <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo
//   PS/2 device-to-host receiver with a 2**FIFO_AW deep scan-code FIFO and
//   sticky error flags.
//   Ports:
//     clk, clrn          system clock, async active-low reset
//     ps2_clk, ps2_data  raw PS/2 pins
//     bus (slave)        nextdata_n pop, clr_err, data head byte, ready,
//                        overflow/parity_err/frame_err sticky flags, fill
module ps2_rx_fifo
    import ps2_rx_fifo_pkg::*;
#(
    parameter int FIFO_AW        = 3,
    parameter int SYNC_STAGES    = 3,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          ps2_clk,
    input  logic          ps2_data,
    ps2_rx_fifo_if.slave  bus
);

    localparam int DEPTH = 1 << FIFO_AW;

    logic [7:0]       rx_byte;
    logic             rx_valid, parity_err_p, frame_err_p;

    logic [7:0]       mem [DEPTH];
    logic [FIFO_AW:0] wp, rp;
    logic             empty, full, pop, push_ok, drop;
    logic             overflow, parity_err, frame_err;

    ps2_frame_rx #(
        .SYNC_STAGES    (SYNC_STAGES),
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk          (clk),
        .clrn         (clrn),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .parity_err_p (parity_err_p),
        .frame_err_p  (frame_err_p)
    );

    // Extra pointer MSB separates full from empty when the indices match.
    assign empty   = (wp == rp);
    assign full    = (wp[FIFO_AW] != rp[FIFO_AW]) &&
                     (wp[FIFO_AW-1:0] == rp[FIFO_AW-1:0]);
    assign pop     = ~bus.nextdata_n & ~empty;
    // A pop in the same cycle frees the slot a full FIFO would lack.
    assign push_ok = rx_valid & (~full | pop);
    assign drop    = rx_valid & full & ~pop;

    // Storage is not reset; data is only meaningful while ready is high.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wp[FIFO_AW-1:0]] <= rx_byte;
    end

    // Sticky flags: a new event wins over a coincident clear.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wp         <= '0;
            rp         <= '0;
            overflow   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (push_ok) wp <= wp + 1'b1;
            if (pop)     rp <= rp + 1'b1;
            overflow   <= drop         | (overflow   & ~bus.clr_err);
            parity_err <= parity_err_p | (parity_err & ~bus.clr_err);
            frame_err  <= frame_err_p  | (frame_err  & ~bus.clr_err);
        end
    end

    assign bus.data       = mem[rp[FIFO_AW-1:0]];
    assign bus.ready      = ~empty;
    assign bus.fill       = wp - rp;
    assign bus.overflow   = overflow;
    assign bus.parity_err = parity_err;
    assign bus.frame_err  = frame_err;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
module tb_ps2_rx_fifo;
    import ps2_rx_fifo_pkg::*;

    localparam int AW  = 3;
    localparam int SS  = 3;
    localparam int FL  = 4;
    localparam int TO  = 300;
    localparam int HP  = 15;              // PS/2 half period in clk cycles
    localparam int LAT = SS + FL + 2;     // last fall -> ready

    logic clk = 1'b0;
    logic clrn = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] sb [$];

    ps2_rx_fifo_if #(.FIFO_AW(AW)) bus ();

    ps2_rx_fifo #(
        .FIFO_AW(AW), .SYNC_STAGES(SS), .FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)
    ) u_dut (
        .clk      (clk),
        .clrn     (clrn),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives nbits of a device frame; returns right after the last clock fall
    // with ps2_clk still low. glitch_bit injects a 1-cycle low pulse into the
    // high phase of that bit.
    task automatic send_frame(input logic [7:0] b, input logic flip_par,
                              input logic stop, input int nbits, input int glitch_bit);
        logic [10:0] fr;
        fr = {stop, (~^b) ^ flip_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            if (i > 0) begin
                wait_clk(HP);
                ps2_clk = 1'b1;
            end
            ps2_data = fr[i];
            wait_clk(5);
            if (i == glitch_bit) begin
                ps2_clk = 1'b0;
                wait_clk(1);
                ps2_clk = 1'b1;
            end
            wait_clk(HP - 5);
            ps2_clk = 1'b0;
        end
    endtask

    task automatic release_bus();
        wait_clk(HP);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_clk(HP);
    endtask

    task automatic send_good(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b1, PS2_FRAME_BITS, -1);
        release_bus();
    endtask

    task automatic clear_errs();
        bus.clr_err = 1'b1;
        wait_clk(1);
        bus.clr_err = 1'b0;
    endtask

    // Pops everything the DUT offers and checks it against the scoreboard.
    task automatic drain();
        for (int k = 0; k < 2 * (1 << AW) + 2; k++) begin
            if (!bus.ready) break;
            if (sb.size() == 0) begin
                chk("extra_byte_ready", bus.ready, 1'b0);
                break;
            end
            chk("pop_data", bus.data, sb.pop_front());
            bus.nextdata_n = 1'b0;
            wait_clk(1);
            bus.nextdata_n = 1'b1;
        end
        chk("drain_sb_left", sb.size(), 0);
        chk("drain_ready", bus.ready, 1'b0);
        chk("drain_fill", bus.fill, 0);
    endtask

    initial begin
        int n;
        bus.nextdata_n = 1'b1;
        bus.clr_err    = 1'b0;

        // Reset state
        wait_clk(3);
        chk("rst_ready", bus.ready, 1'b0);
        chk("rst_fill", bus.fill, 0);
        chk("rst_overflow", bus.overflow, 1'b0);
        chk("rst_parity_err", bus.parity_err, 1'b0);
        chk("rst_frame_err", bus.frame_err, 1'b0);
        clrn = 1'b1;
        wait_clk(SS + FL + 5);
        chk("post_rst_ready", bus.ready, 1'b0);
        chk("post_rst_frame_err", bus.frame_err, 1'b0);

        // Single byte with latency measurement
        send_frame(8'h1C, 1'b0, 1'b1, PS2_FRAME_BITS, -1);
        n = 0;
        while (!bus.ready && n < 40) begin
            wait_clk(1);
            n++;
        end
        chk("latency", (n >= LAT - 1 && n <= LAT + 1) ? LAT : n, LAT);
        sb.push_back(8'h1C);
        chk("one_fill", bus.fill, 1);
        release_bus();
        drain();

        // Bad parity
        send_frame(8'h1C, 1'b1, 1'b1, PS2_FRAME_BITS, -1);
        release_bus();
        chk("par_parity_err", bus.parity_err, 1'b1);
        chk("par_ready", bus.ready, 1'b0);
        chk("par_frame_err", bus.frame_err, 1'b0);
        clear_errs();
        chk("par_cleared", bus.parity_err, 1'b0);

        // Bad stop bit
        send_frame(8'h33, 1'b0, 1'b0, PS2_FRAME_BITS, -1);
        release_bus();
        chk("stop_frame_err", bus.frame_err, 1'b1);
        chk("stop_parity_err", bus.parity_err, 1'b0);
        chk("stop_ready", bus.ready, 1'b0);
        clear_errs();
        chk("stop_cleared", bus.frame_err, 1'b0);

        // Overflow: 9 bytes into an 8-deep FIFO, the 9th is dropped
        for (int b = 1; b <= 9; b++) begin
            send_good(8'(b));
            if (sb.size() < (1 << AW)) sb.push_back(8'(b));
        end
        chk("ovf_fill", bus.fill, 1 << AW);
        chk("ovf_flag", bus.overflow, 1'b1);
        drain();
        chk("ovf_sticky", bus.overflow, 1'b1);
        clear_errs();
        chk("ovf_cleared", bus.overflow, 1'b0);

        // Timeout on a partial frame, then a clean frame
        send_frame(8'h00, 1'b0, 1'b1, 5, -1);
        release_bus();
        wait_clk(60);
        chk("to_not_yet", bus.frame_err, 1'b0);
        wait_clk(TO);
        chk("to_frame_err", bus.frame_err, 1'b1);
        clear_errs();
        send_good(8'h5A);
        sb.push_back(8'h5A);
        chk("to_after_frame_err", bus.frame_err, 1'b0);
        chk("to_after_fill", bus.fill, 1);
        drain();

        // Single-cycle glitch on ps2_clk mid-frame
        send_frame(8'hA5, 1'b0, 1'b1, PS2_FRAME_BITS, 4);
        release_bus();
        sb.push_back(8'hA5);
        chk("gl_frame_err", bus.frame_err, 1'b0);
        chk("gl_parity_err", bus.parity_err, 1'b0);
        chk("gl_fill", bus.fill, 1);
        drain();

        // Full FIFO, pop coincides with the push of 0xAA
        for (int b = 0; b < (1 << AW); b++) begin
            send_good(8'h10 + 8'(b));
            sb.push_back(8'h10 + 8'(b));
        end
        chk("sim_full", bus.fill, 1 << AW);
        send_frame(8'hAA, 1'b0, 1'b1, PS2_FRAME_BITS, -1);
        wait_clk(LAT - 1);
        chk("sim_head", bus.data, sb.pop_front());
        bus.nextdata_n = 1'b0;
        wait_clk(1);
        bus.nextdata_n = 1'b1;
        sb.push_back(8'hAA);
        release_bus();
        chk("sim_fill", bus.fill, 1 << AW);
        chk("sim_overflow", bus.overflow, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
